priority_decoder_seq: RTL and testbench

- Decoder end of the generic priority encoder interface.
- Accepts an encoded (z valid, y index) stream, as produced by the priority encoder, through a valid/ready handshake.
- Expands each valid index into a registered one-hot word on a valid/ready output stage.
- Keeps a sticky vector of all indices seen, a saturating event counter and a sticky range-error flag, so downstream logic can reconstruct the original request set.

---
 rtl/priority_decoder_seq.sv | 125 ++++++++++++
 tb/tb_priority_decoder_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq: decoder end of the priority encoder interface.
// Takes (z, y) index events through a valid/ready handshake and expands each
// in-range index into a registered one-hot word on a valid/ready output stage.
// It also keeps a sticky record of the indices seen, a saturating event count
// and a sticky range-error flag.
module priority_decoder_seq #(
    parameter int N  = 6,
    parameter int CW = 8,
    localparam int W = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          z,
    input  logic [W-1:0]  y,
    output logic          in_ready,
    output logic [N-1:0]  d,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [N-1:0]  pending,
    output logic [CW-1:0] cnt,
    output logic          err,
    input  logic          clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One extra bit so that an N equal to 2**W can still be represented.
    localparam logic [W:0] N_LIM = (W + 1)'(N);

    state_t        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          accept;
    logic          in_range;
    logic          take;
    logic [N-1:0]  word;

    // The counter stops at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Handshake and decode; in_ready depends only on the output stage.
    always_comb begin
        d_valid  = (state_q == FULL);
        in_ready = !d_valid || d_ready;
        accept   = z && in_ready;
        in_range = ({1'b0, y} < N_LIM);
        take     = accept && in_range;
        word     = N'(1) << y;
    end

    // Output stage next state: load on an in-range accept, drain when consumed.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        case (state_q)
            EMPTY: begin
                if (take) begin
                    state_d = FULL;
                    d_d     = word;
                end
            end
            FULL: begin
                if (d_ready) begin
                    if (take) begin
                        state_d = FULL;
                        d_d     = word;
                    end else begin
                        state_d = EMPTY;
                        d_d     = '0;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                d_d     = '0;
            end
        endcase
    end

    // Sticky status: clr empties it first, then the current event is merged in
    // so an event coinciding with clr is never lost.
    always_comb begin
        pending_d = clr ? '0 : pending_q;
        cnt_d     = clr ? '0 : cnt_q;
        err_d     = clr ? 1'b0 : err_q;
        if (take) begin
            pending_d = pending_d | word;
            cnt_d     = sat_inc(cnt_d);
        end
        if (accept && !in_range) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            d_q       <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign d       = d_q;
    assign pending = pending_q;
    assign cnt     = cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq with N=6, CW=3: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_priority_decoder_seq;

    localparam int N  = 6;
    localparam int CW = 3;
    localparam int W  = $clog2(N);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset_n;
    logic          z;
    logic [W-1:0]  y;
    logic          in_ready;
    logic [N-1:0]  d;
    logic          d_valid;
    logic          d_ready;
    logic [N-1:0]  pending;
    logic [CW-1:0] cnt;
    logic          err;
    logic          clr;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    // Behavioural model of what the outputs must be.
    bit m_full;
    int m_idx;
    int m_pend;
    int m_cnt;
    bit m_err;

    priority_decoder_seq #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .z        (z),
        .y        (y),
        .in_ready (in_ready),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .pending  (pending),
        .cnt      (cnt),
        .err      (err),
        .clr      (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0;
        m_idx  = 0;
        m_pend = 0;
        m_cnt  = 0;
        m_err  = 0;
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_step();
        bit acc;
        bit inr;
        int yi;
        yi  = int'(y);
        acc = z && (!m_full || d_ready);
        inr = (yi < N);
        if (!(m_full && !d_ready)) begin
            if (acc && inr) begin
                m_full = 1;
                m_idx  = yi;
            end else begin
                m_full = 0;
            end
        end
        if (clr) begin
            m_pend = 0;
            m_cnt  = 0;
            m_err  = 0;
        end
        if (acc && inr) begin
            m_pend = m_pend | (1 << yi);
            m_cnt  = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        end
        if (acc && !inr) m_err = 1;
    endtask

    task automatic step(input bit zz, input int yy, input bit rdy, input bit cc);
        logic [31:0] yv;
        yv      = yy;
        z       = zz;
        y       = yv[W-1:0];
        d_ready = rdy;
        clr     = cc;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("d",        32'(d),       m_full ? (32'd1 << m_idx) : 32'd0);
            chk("d_valid",  32'(d_valid), 32'(m_full));
            chk("in_ready", 32'(in_ready), 32'(!m_full || d_ready));
            chk("pending",  32'(pending), 32'(m_pend));
            chk("cnt",      32'(cnt),     32'(m_cnt));
            chk("err",      32'(err),     32'(m_err));
        end
    end

    initial begin
        z = 0; y = '0; d_ready = 0; clr = 0;
        reset_n = 0;
        model_reset();
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d", 32'(d), 32'h0);
        chk("rst_dv", 32'(d_valid), 32'h0);
        chk("rst_inr", 32'(in_ready), 32'h1);
        chk("rst_cnt", 32'(cnt), 32'h0);
        reset_n = 1;

        // Stream 0..5 back to back.
        for (int i = 0; i < 6; i++) begin
            step(1, i, 1, 0);
            chk("stream_d", 32'(d), 32'd1 << i);
            chk("stream_dv", 32'(d_valid), 32'h1);
        end
        chk("stream_pend", 32'(pending), 32'h3f);
        chk("stream_cnt", 32'(cnt), 32'd6);
        step(0, 0, 1, 0);
        chk("drain_dv", 32'(d_valid), 32'h0);

        // Backpressure holds the word.
        step(1, 3, 1, 0);
        chk("hold_load", 32'(d), 32'h08);
        for (int i = 0; i < 4; i++) begin
            step(1, i, 0, 0);
            chk("hold_d", 32'(d), 32'h08);
            chk("hold_dv", 32'(d_valid), 32'h1);
            chk("hold_inr", 32'(in_ready), 32'h0);
        end
        step(0, 0, 1, 0);
        chk("release_dv", 32'(d_valid), 32'h0);
        chk("release_d", 32'(d), 32'h0);

        // Out-of-range indices.
        step(0, 0, 1, 1);
        step(1, 6, 1, 0);
        chk("oor6_dv", 32'(d_valid), 32'h0);
        chk("oor6_err", 32'(err), 32'h1);
        step(1, 7, 1, 0);
        chk("oor7_err", 32'(err), 32'h1);
        chk("oor_cnt", 32'(cnt), 32'h0);
        chk("oor_pend", 32'(pending), 32'h0);
        step(0, 0, 1, 1);
        chk("clr_err", 32'(err), 32'h0);
        step(1, 7, 1, 1);
        chk("clr_vs_oor", 32'(err), 32'h1);

        // clr together with an accept keeps the new event.
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        step(1, 2, 1, 0);
        chk("pre_pend", 32'(pending), 32'h05);
        chk("pre_cnt", 32'(cnt), 32'd2);
        step(1, 4, 1, 1);
        chk("clracc_pend", 32'(pending), 32'h10);
        chk("clracc_cnt", 32'(cnt), 32'd1);
        chk("clracc_d", 32'(d), 32'h10);

        // Saturation, then asynchronous reset while a word is held.
        step(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) step(1, i % 6, 1, 0);
        chk("sat_cnt", 32'(cnt), 32'd7);
        chk("sat_dv", 32'(d_valid), 32'h1);
        #1;
        reset_n = 0;
        model_reset();
        #1;
        chk("async_d", 32'(d), 32'h0);
        chk("async_dv", 32'(d_valid), 32'h0);
        chk("async_cnt", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1;

        // z low: y ignored entirely.
        step(1, 1, 1, 0);
        step(1, 7, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, i % 8, 1, 0);
            chk("zlow_dv", 32'(d_valid), 32'h0);
        end
        chk("zlow_pend", 32'(pending), 32'h02);
        chk("zlow_cnt", 32'(cnt), 32'd1);
        chk("zlow_err", 32'(err), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
